// File: rtl/sar_track_ctrl_if.sv
// Handshake bundle between the phase detector / loop supervisor and the
// SAR tracking controller. The master drives start/COMP, the slave (the
// controller) returns the code, its thermometer decode and the status flags.
interface sar_track_ctrl_if #(
  parameter int WIDTH      = 10,
  parameter int THERM_BITS = 4
) ();
  logic                           start;
  logic                           COMP;
  logic [WIDTH-1:0]               Q;
  logic [(1 << THERM_BITS)-2:0]   T;
  logic [(1 << THERM_BITS)-2:0]   Tb;
  logic                           busy;
  logic                           done;
  logic                           tracking;
  logic                           locked;

  modport master (
    output start, COMP,
    input  Q, T, Tb, busy, done, tracking, locked
  );

  modport slave (
    input  start, COMP,
    output Q, T, Tb, busy, done, tracking, locked
  );
endinterface

// File: rtl/sar_track_ctrl.sv
// SAR delay-line control loop: binary search on the control code from the
// phase-detector result, then +/-1 tracking with lock detection on a run of
// direction reversals. The coarse-cell thermometer is registered with Q.
module sar_track_ctrl #(
  parameter int WIDTH      = 10,
  parameter int THERM_BITS = 4,
  parameter int SETTLE     = 2,
  parameter int LOCK_CNT   = 8
) (
  input  logic          clk4,
  input  logic          rst,
  sar_track_ctrl_if.slave bus
);
  localparam int TW = (1 << THERM_BITS) - 1;
  localparam int BW = $clog2(WIDTH);
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [BW-1:0]   b_q, b_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [7:0]      lcnt_q, lcnt_d;
  logic            pdir_q, pdir_d;
  logic            pvld_q, pvld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            trk_q, trk_d;
  logic            lck_q, lck_d;
  logic [TW-1:0]   t_q, t_d;
  logic [THERM_BITS-1:0] m;

  // Next-state: start restarts from midscale; otherwise act only on settled edges.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    b_d     = b_q;
    wcnt_d  = (wcnt_q != '0) ? wcnt_q - 1'b1 : wcnt_q;
    lcnt_d  = lcnt_q;
    pdir_d  = pdir_q;
    pvld_d  = pvld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    trk_d   = trk_q;
    lck_d   = lck_q;
    if (bus.start) begin
      state_d        = SEARCH;
      q_d            = '0;
      q_d[WIDTH-1]   = 1'b1;
      b_d            = BW'(WIDTH - 1);
      wcnt_d         = WW'(SETTLE);
      busy_d         = 1'b1;
      trk_d          = 1'b0;
      lck_d          = 1'b0;
      lcnt_d         = '0;
      pvld_d         = 1'b0;
    end else if (wcnt_q == '0) begin
      case (state_q)
        SEARCH: begin
          q_d[b_q] = bus.COMP;
          wcnt_d   = WW'(SETTLE);
          if (b_q != '0) begin
            q_d[b_q - 1'b1] = 1'b1;
            b_d             = b_q - 1'b1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            trk_d   = 1'b1;
            state_d = TRACK;
            pvld_d  = 1'b0;
          end
        end
        TRACK: begin
          wcnt_d = WW'(SETTLE);
          // A saturated step is still a step in its direction for lock purposes.
          if (bus.COMP) begin
            if (q_q != '1) q_d = q_q + 1'b1;
          end else begin
            if (q_q != '0) q_d = q_q - 1'b1;
          end
          if (pvld_q) begin
            if (bus.COMP != pdir_q) begin
              if (lcnt_q < 8'(LOCK_CNT)) lcnt_d = lcnt_q + 8'd1;
              if (lcnt_d == 8'(LOCK_CNT)) lck_d = 1'b1;
            end else begin
              lcnt_d = '0;
              lck_d  = 1'b0;
            end
          end
          pdir_d = bus.COMP;
          pvld_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Thermometer of the next code's MSB field so T lands on the same edge as Q.
  always_comb begin
    m = q_d[WIDTH-1 -: THERM_BITS];
    t_d = '0;
    for (int i = 0; i < TW; i++) t_d[i] = (THERM_BITS'(i) < m);
  end

  // Loop state and registered outputs.
  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      b_q     <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      pdir_q  <= 1'b0;
      pvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trk_q   <= 1'b0;
      lck_q   <= 1'b0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      b_q     <= b_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      pdir_q  <= pdir_d;
      pvld_q  <= pvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trk_q   <= trk_d;
      lck_q   <= lck_d;
      t_q     <= t_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.T        = t_q;
  assign bus.Tb       = ~t_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tracking = trk_q;
  assign bus.locked   = lck_q;
endmodule
